if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_3000, which is the PC value loaded on reset.
REQ-002 The block SHALL provide parameter IM_BASE, default 32'h0000_3000, which is the lowest legal fetch address.
REQ-003 The block SHALL provide parameter IM_WORDS, default 4096, which is the instruction memory depth in words.
REQ-004 The block SHALL have these ports:
- clk, input, 1 bit: single clock; all state updates on the rising edge.
- reset, input, 1 bit: synchronous, active-high reset.
- stall, input, 1 bit: hold the PC and the IF/ID register.
- flush, input, 1 bit: load a bubble into the IF/ID register.
- nextPC, input, 32 bits: next fetch address from the next-PC logic.
- instr_in, input, 32 bits: instruction memory read data, combinational at address PC.
- PC, output, 32 bits: current fetch address; drives the instruction memory address and the next-PC logic.
- D_PC, output, 32 bits: PC of the instruction held in IF/ID.
- D_instr, output, 32 bits: instruction held in IF/ID.
- D_valid, output, 1 bit: IF/ID holds a real instruction, not a bubble.
- D_exc, output, 1 bit: the IF/ID instruction raised a fetch fault.
- fetch_cnt, output, 32 bits: count of valid instructions passed into IF/ID.

Function
REQ-005 The PC register SHALL load nextPC on every rising edge where reset=0 and stall=0.
REQ-006 The PC register SHALL hold its value when stall=1, regardless of flush.
REQ-007 Fetch fault SHALL be defined as fault = (PC[1:0]!=0) or (PC<IM_BASE) or (PC>=IM_BASE+4*IM_WORDS), evaluated combinationally on the current PC.
REQ-008 When fault=1, the word captured into IF/ID SHALL be 32'h0000_0000 (nop), not instr_in.
REQ-009 When fault=0, the word captured into IF/ID SHALL be instr_in.
REQ-010 The IF/ID register SHALL update with these priorities:
- reset: highest priority.
- flush=1: D_PC<=PC, D_instr<=0, D_valid<=0, D_exc<=0.
- stall=1 and flush=0: all IF/ID fields hold.
- otherwise: D_PC<=PC, D_instr<=captured word, D_valid<=1, D_exc<=fault.
REQ-011 When flush and stall are both 1, the IF/ID register SHALL take the bubble while the PC holds.
REQ-012 fetch_cnt SHALL increment by 1 on each edge where IF/ID loads with D_valid<=1.
REQ-013 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-014 fetch_cnt SHALL hold on stall, on flush, and on any edge where nothing is loaded.
REQ-015 A faulting fetch that is loaded into IF/ID SHALL still count in fetch_cnt (D_valid=1, D_exc=1).
REQ-016 The block SHALL impose zero added latency: an instruction at PC appears on D_instr in the cycle after it is fetched.
REQ-017 The block SHALL NOT compute PC+4 itself; it SHALL consume nextPC unchanged, including misaligned values, which REQ-007 then flags.

Reset
REQ-018 On a rising edge with reset=1, the block SHALL load PC<=RESET_PC, D_PC<=0, D_instr<=0, D_valid<=0, D_exc<=0, fetch_cnt<=0.
REQ-019 Reset SHALL override stall and flush.
REQ-020 Reset asserted mid-stream SHALL discard the IF/ID contents within that single edge.
REQ-021 Outputs SHALL be undefined only before the first reset edge; the bench SHALL apply reset for at least 1 cycle.

Verification
REQ-022 The bench SHALL cover sequential fetch:
- Stimulus: reset, then nextPC=PC+4 each cycle, with instr_in = PC-derived words.
- Required response: PC runs 0x3000, 0x3004, 0x3008; D_PC lags PC by one cycle; D_valid=1 from the second edge; fetch_cnt=3 after 3 loads.
REQ-023 The bench SHALL cover stall:
- Stimulus: stall=1 for 2 cycles at PC=0x3008.
- Required response: PC, D_PC and D_instr hold for 2 cycles; fetch_cnt holds; fetch resumes at 0x3008's nextPC.
REQ-024 The bench SHALL cover flush, alone and with stall:
- Stimulus: flush=1 for one cycle; then flush=1 and stall=1 together.
- Required response (flush alone): D_valid=0 and D_instr=0 while PC advances.
- Required response (both): D_valid=0 and PC holds.
REQ-025 The bench SHALL cover fetch faults:
- Stimulus: nextPC=0x3002; separately nextPC=0x7000 and nextPC=0x2FFC.
- Required response: each yields D_exc=1, D_instr=0, D_valid=1, and fetch_cnt increments.
REQ-026 The bench SHALL cover the last legal address:
- Stimulus: nextPC=0x6FFC.
- Required response: D_exc=0 and D_instr=instr_in.
REQ-027 The bench SHALL cover reset mid-operation:
- Stimulus: assert reset while stall=1 and flush=1 at PC=0x4000.
- Required response: next edge gives PC=0x3000, D_valid=0, and fetch_cnt=0.
REQ-028 The bench SHALL cover counter wrap:
- Stimulus: force fetch_cnt=32'hFFFF_FFFF, then one valid load.
- Required response: fetch_cnt=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch-fault detection and the IF/ID pipeline register.
// Latency: one cycle. The word fetched at PC appears on D_instr after the next rising edge.
// Backpressure: stall holds PC and IF/ID. Flush loads a bubble into IF/ID, and PC still holds if stall is also set.
//
// Ports:
//   clk, reset       : single clock; synchronous active-high reset
//   stall, flush     : pipeline hold / bubble insertion controls
//   nextPC           : next fetch address, consumed unchanged
//   instr_in         : instruction memory read data for the current PC
//   PC               : current fetch address
//   D_PC, D_instr    : IF/ID register contents
//   D_valid, D_exc   : IF/ID holds a real instruction / that instruction faulted
//   fetch_cnt        : number of valid instructions loaded into IF/ID (wraps)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] nextPC,
  input  logic [31:0] instr_in,
  output logic [31:0] PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic        D_exc,
  output logic [31:0] fetch_cnt
);

  // One past the last legal byte address of instruction memory.
  localparam logic [31:0] IM_BYTES = 32'(IM_WORDS) << 2;
  localparam logic [31:0] IM_END   = IM_BASE + IM_BYTES;

  logic        fault;
  logic [31:0] fetch_word;
  logic        load_valid;

  // A faulting fetch is replaced by a nop so stale or out-of-range data never
  // reaches decode; D_exc carries the fault downstream instead.
  always_comb begin
    fault      = (PC[1:0] != 2'b00) || (PC < IM_BASE) || (PC >= IM_END);
    fetch_word = fault ? 32'h0000_0000 : instr_in;
    load_valid = !stall && !flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC        <= RESET_PC;
      D_PC      <= 32'h0000_0000;
      D_instr   <= 32'h0000_0000;
      D_valid   <= 1'b0;
      D_exc     <= 1'b0;
      fetch_cnt <= 32'h0000_0000;
    end else begin
      if (!stall) begin
        PC <= nextPC;
      end

      // Flush wins over stall for IF/ID, so a stalled stage can still be
      // bubbled while the PC keeps its value.
      if (flush) begin
        D_PC    <= PC;
        D_instr <= 32'h0000_0000;
        D_valid <= 1'b0;
        D_exc   <= 1'b0;
      end else if (load_valid) begin
        D_PC      <= PC;
        D_instr   <= fetch_word;
        D_valid   <= 1'b1;
        D_exc     <= fault;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] next_pc;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_valid;
  logic        d_exc;
  logic [31:0] fetch_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  if_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .nextPC    (next_pc),
    .instr_in  (instr_in),
    .PC        (pc),
    .D_PC      (d_pc),
    .D_instr   (d_instr),
    .D_valid   (d_valid),
    .D_exc     (d_exc),
    .fetch_cnt (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: every address returns a distinct non-zero word.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always_comb instr_in = word_at(pc);

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; flush = 1'b1; next_pc = 32'h1234_5678;
    step();
    step();
    total_cnt++; if (pc !== 32'h3000) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); else pass_cnt++;
    total_cnt++; if (d_pc !== 32'h0) $display("FAIL reset_d_pc got=%h exp=0", d_pc); else pass_cnt++;
    total_cnt++; if (d_instr !== 32'h0) $display("FAIL reset_d_instr got=%h exp=0", d_instr); else pass_cnt++;
    total_cnt++; if (d_valid !== 1'b0) $display("FAIL reset_d_valid got=%b exp=0", d_valid); else pass_cnt++;
    total_cnt++; if (d_exc !== 1'b0) $display("FAIL reset_d_exc got=%b exp=0", d_exc); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 32'h0) $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); else pass_cnt++;
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      next_pc = exp_pc + 32'd4;
      step();
      total_cnt++; if (pc !== exp_pc + 32'd4) $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc + 32'd4); else pass_cnt++;
      total_cnt++; if (d_pc !== exp_pc) $display("FAIL seq_d_pc[%0d] got=%h exp=%h", i, d_pc, exp_pc); else pass_cnt++;
      total_cnt++; if (d_instr !== word_at(exp_pc)) $display("FAIL seq_d_instr[%0d] got=%h exp=%h", i, d_instr, word_at(exp_pc)); else pass_cnt++;
      total_cnt++; if (d_valid !== 1'b1 || d_exc !== 1'b0) $display("FAIL seq_flags[%0d] got=%b%b exp=10", i, d_valid, d_exc); else pass_cnt++;
      total_cnt++; if (fetch_cnt !== 32'(i + 1)) $display("FAIL seq_cnt[%0d] got=%0d exp=%0d", i, fetch_cnt, i + 1); else pass_cnt++;
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // Entered with PC=0x300C, IF/ID holding 0x3008, fetch_cnt=3.
  task automatic test_stall();
    stall = 1'b1; next_pc = 32'h5555_0000;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++; if (pc !== 32'h300C) $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc, 32'h300C); else pass_cnt++;
      total_cnt++; if (d_pc !== 32'h3008) $display("FAIL stall_d_pc[%0d] got=%h exp=%h", i, d_pc, 32'h3008); else pass_cnt++;
      total_cnt++; if (d_instr !== word_at(32'h3008)) $display("FAIL stall_d_instr[%0d] got=%h exp=%h", i, d_instr, word_at(32'h3008)); else pass_cnt++;
      total_cnt++; if (fetch_cnt !== 32'd3) $display("FAIL stall_cnt[%0d] got=%0d exp=3", i, fetch_cnt); else pass_cnt++;
    end
    stall = 1'b0; next_pc = 32'h3010;
    step();
    total_cnt++; if (pc !== 32'h3010) $display("FAIL resume_pc got=%h exp=%h", pc, 32'h3010); else pass_cnt++;
    total_cnt++; if (d_pc !== 32'h300C || d_instr !== word_at(32'h300C)) $display("FAIL resume_d got=%h/%h exp=%h/%h", d_pc, d_instr, 32'h300C, word_at(32'h300C)); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 32'd4) $display("FAIL resume_cnt got=%0d exp=4", fetch_cnt); else pass_cnt++;
  endtask

  // Entered with PC=0x3010, fetch_cnt=4.
  task automatic test_flush();
    flush = 1'b1; next_pc = 32'h3014;
    step();
    total_cnt++; if (pc !== 32'h3014) $display("FAIL flush_pc got=%h exp=%h", pc, 32'h3014); else pass_cnt++;
    total_cnt++; if (d_valid !== 1'b0 || d_instr !== 32'h0) $display("FAIL flush_bubble got=%b/%h exp=0/0", d_valid, d_instr); else pass_cnt++;
    total_cnt++; if (d_pc !== 32'h3010) $display("FAIL flush_d_pc got=%h exp=%h", d_pc, 32'h3010); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 32'd4) $display("FAIL flush_cnt got=%0d exp=4", fetch_cnt); else pass_cnt++;

    // Restore a valid IF/ID entry so the combined case visibly turns it into a bubble.
    flush = 1'b0; next_pc = 32'h3014;
    step();
    total_cnt++; if (d_valid !== 1'b1 || fetch_cnt !== 32'd5) $display("FAIL refill got=%b/%0d exp=1/5", d_valid, fetch_cnt); else pass_cnt++;

    flush = 1'b1; stall = 1'b1; next_pc = 32'h3018;
    step();
    total_cnt++; if (pc !== 32'h3014) $display("FAIL flush_stall_pc got=%h exp=%h", pc, 32'h3014); else pass_cnt++;
    total_cnt++; if (d_valid !== 1'b0 || d_instr !== 32'h0 || d_exc !== 1'b0) $display("FAIL flush_stall_bubble got=%b/%h/%b exp=0/0/0", d_valid, d_instr, d_exc); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 32'd5) $display("FAIL flush_stall_cnt got=%0d exp=5", fetch_cnt); else pass_cnt++;
    flush = 1'b0; stall = 1'b0;
  endtask

  // Entered with PC=0x3014, fetch_cnt=5. Each row's address is fetched and
  // checked on the following edge; the last legal word closes the table.
  task automatic test_fault();
    logic [31:0] addr [5];
    logic        exc  [4];
    addr[0] = 32'h3002; addr[1] = 32'h7000; addr[2] = 32'h2FFC;
    addr[3] = 32'h6FFC; addr[4] = 32'h4000;
    exc[0] = 1'b1; exc[1] = 1'b1; exc[2] = 1'b1; exc[3] = 1'b0;
    next_pc = addr[0];
    step();
    total_cnt++; if (pc !== 32'h3002) $display("FAIL misaligned_pc got=%h exp=%h", pc, 32'h3002); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      next_pc = addr[i + 1];
      step();
      total_cnt++; if (pc !== addr[i + 1]) $display("FAIL fault_pc[%0d] got=%h exp=%h", i, pc, addr[i + 1]); else pass_cnt++;
      total_cnt++; if (d_pc !== addr[i]) $display("FAIL fault_d_pc[%0d] got=%h exp=%h", i, d_pc, addr[i]); else pass_cnt++;
      total_cnt++; if (d_exc !== exc[i]) $display("FAIL fault_exc[%0d] got=%b exp=%b", i, d_exc, exc[i]); else pass_cnt++;
      total_cnt++; if (d_instr !== (exc[i] ? 32'h0 : word_at(addr[i]))) $display("FAIL fault_instr[%0d] got=%h exp=%h", i, d_instr, exc[i] ? 32'h0 : word_at(addr[i])); else pass_cnt++;
      total_cnt++; if (d_valid !== 1'b1) $display("FAIL fault_valid[%0d] got=%b exp=1", i, d_valid); else pass_cnt++;
      total_cnt++; if (fetch_cnt !== 32'(7 + i)) $display("FAIL fault_cnt[%0d] got=%0d exp=%0d", i, fetch_cnt, 7 + i); else pass_cnt++;
    end
  endtask

  // Entered with PC=0x4000 and a valid entry in IF/ID.
  task automatic test_reset_mid();
    total_cnt++; if (pc !== 32'h4000) $display("FAIL mid_pre_pc got=%h exp=%h", pc, 32'h4000); else pass_cnt++;
    reset = 1'b1; stall = 1'b1; flush = 1'b1; next_pc = 32'h5000;
    step();
    total_cnt++; if (pc !== 32'h3000) $display("FAIL mid_reset_pc got=%h exp=%h", pc, 32'h3000); else pass_cnt++;
    total_cnt++; if (d_valid !== 1'b0 || d_pc !== 32'h0 || d_instr !== 32'h0) $display("FAIL mid_reset_ifid got=%b/%h/%h exp=0/0/0", d_valid, d_pc, d_instr); else pass_cnt++;
    total_cnt++; if (fetch_cnt !== 32'h0) $display("FAIL mid_reset_cnt got=%0d exp=0", fetch_cnt); else pass_cnt++;
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_wrap();
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt;
    next_pc = 32'h3004;
    step();
    total_cnt++; if (fetch_cnt !== 32'h0) $display("FAIL wrap_cnt got=%h exp=0", fetch_cnt); else pass_cnt++;
    total_cnt++; if (d_valid !== 1'b1 || d_pc !== 32'h3000) $display("FAIL wrap_load got=%b/%h exp=1/%h", d_valid, d_pc, 32'h3000); else pass_cnt++;
    next_pc = 32'h3008;
    step();
    total_cnt++; if (fetch_cnt !== 32'h1) $display("FAIL wrap_next_cnt got=%h exp=1", fetch_cnt); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; next_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_fault();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
